// File: rtl/ibex_rf_wr_ctrl.sv
// ibex_rf_wr_ctrl
// Register-file write-port controller. After reset, or on a scrub request,
// it writes WordZeroVal to registers 1..NUM_WORDS-1 (INIT). It then
// arbitrates WB-stage writes (fixed priority, never stalled) against LSU
// writes (request/grant). Every accepted write is staged one cycle before
// it reaches the register file.
//
// Ports
//   clk_i        sole clock
//   rst_ni       synchronous active-low reset
//   init_req_i   scrub request pulse (honoured in RUN when no write is accepted)
//   init_done_o  high while in RUN
//   we_wb_i      WB write strobe, no backpressure
//   waddr_wb_i   WB write address
//   wdata_wb_i   WB write data
//   req_lsu_i    LSU write request, held until granted
//   waddr_lsu_i  LSU write address
//   wdata_lsu_i  LSU write data
//   gnt_lsu_o    LSU grant, same cycle as the request
//   stall_wb_o   WB must not write in the next cycle
//   rf_we_o      register file write enable
//   rf_waddr_o   register file write address
//   rf_wdata_o   register file write data
//   err_o        one-cycle protocol-violation pulse
module ibex_rf_wr_ctrl #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter int unsigned          MaxWait     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_req_i,
  output logic                 init_done_o,
  input  logic                 we_wb_i,
  input  logic [4:0]           waddr_wb_i,
  input  logic [DataWidth-1:0] wdata_wb_i,
  input  logic                 req_lsu_i,
  input  logic [4:0]           waddr_lsu_i,
  input  logic [DataWidth-1:0] wdata_lsu_i,
  output logic                 gnt_lsu_o,
  output logic                 stall_wb_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 err_o
);

  localparam int unsigned NumWords = RV32E ? 32'd16 : 32'd32;
  localparam logic [4:0]  LastCnt  = 5'(NumWords - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [4:0]           r_cnt, w_cnt_nxt;
  logic [3:0]           r_wait, w_wait_nxt;
  logic                 r_we, w_we_nxt;
  logic [4:0]           r_waddr, w_waddr_nxt;
  logic [DataWidth-1:0] r_wdata, w_wdata_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_stall_q;

  logic                 w_run;
  logic                 w_scrub;
  logic                 w_gnt;
  logic                 w_stall;
  logic                 w_acc;
  logic                 w_bad_addr;
  logic [4:0]           w_acc_addr;
  logic [DataWidth-1:0] w_acc_data;

  assign w_run      = (r_state == S_RUN);
  assign w_scrub    = rst_ni & ~w_run;
  assign w_gnt      = rst_ni & w_run & req_lsu_i & ~we_wb_i;
  assign w_stall    = ~rst_ni | ~w_run | (32'(r_wait) >= MaxWait);
  assign w_acc      = w_run & (we_wb_i | w_gnt);
  assign w_acc_addr = we_wb_i ? waddr_wb_i : waddr_lsu_i;
  assign w_acc_data = we_wb_i ? wdata_wb_i : wdata_lsu_i;
  assign w_bad_addr = RV32E & w_acc_addr[4];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wait_nxt  = r_wait;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_INIT: begin
        // Track the scrub address so rf_* still shows the last write after INIT.
        w_waddr_nxt = r_cnt;
        w_wdata_nxt = WordZeroVal;
        w_err_nxt   = we_wb_i;
        w_wait_nxt  = '0;
        if (r_cnt == LastCnt) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 5'd1;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      S_RUN: begin
        if (w_acc) begin
          w_err_nxt = w_bad_addr | (we_wb_i & r_stall_q);
          if (!w_bad_addr && (w_acc_addr != '0)) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = w_acc_addr;
            w_wdata_nxt = w_acc_data;
          end
        end else if (init_req_i) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = 5'd1;
        end
        if (req_lsu_i && !w_gnt) begin
          w_wait_nxt = (r_wait == 4'hF) ? r_wait : r_wait + 4'd1;
        end else begin
          w_wait_nxt = '0;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_INIT;
      r_cnt     <= 5'd1;
      r_wait    <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= WordZeroVal;
      r_err     <= 1'b0;
      r_stall_q <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wait    <= w_wait_nxt;
      r_we      <= w_we_nxt;
      r_waddr   <= w_waddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_err     <= w_err_nxt;
      r_stall_q <= w_stall;
    end
  end

  // Scrub writes are decoded directly from state/cnt rather than staged, so
  // the first one appears in the cycle INIT is entered. Outputs are gated by
  // rst_ni so a reset asserted mid-cycle is visible before the clock edge.
  assign init_done_o = rst_ni & w_run;
  assign gnt_lsu_o   = w_gnt;
  assign stall_wb_o  = w_stall;
  assign rf_we_o     = rst_ni & (~w_run | r_we);
  assign rf_waddr_o  = w_scrub ? r_cnt : r_waddr;
  assign rf_wdata_o  = w_scrub ? WordZeroVal : r_wdata;
  assign err_o       = rst_ni & r_err;

endmodule

// File: tb/tb_ibex_rf_wr_ctrl.sv
// Testbench for ibex_rf_wr_ctrl: a 32-register instance checked every cycle
// against a queue-based reference model, a table of directed vectors, hand
// sequences for init/stall/scrub/reset, and a 16-register instance for the
// reduced-address-space behaviour.
module tb_ibex_rf_wr_ctrl;

  localparam int unsigned MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        req = 1'b0;
  logic [4:0]  la = '0;
  logic [31:0] ld = '0;

  logic        d0_done, d0_gnt, d0_stall, d0_we, d0_err;
  logic [4:0]  d0_addr;
  logic [31:0] d0_data;
  logic        d1_done, d1_gnt, d1_stall, d1_we, d1_err;
  logic [4:0]  d1_addr;
  logic [31:0] d1_data;

  ibex_rf_wr_ctrl #(.RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0), .MaxWait(MAXW)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .init_done_o(d0_done),
    .we_wb_i(we), .waddr_wb_i(wa), .wdata_wb_i(wd),
    .req_lsu_i(req), .waddr_lsu_i(la), .wdata_lsu_i(ld),
    .gnt_lsu_o(d0_gnt), .stall_wb_o(d0_stall),
    .rf_we_o(d0_we), .rf_waddr_o(d0_addr), .rf_wdata_o(d0_data), .err_o(d0_err));

  ibex_rf_wr_ctrl #(.RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0), .MaxWait(MAXW)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .init_done_o(d1_done),
    .we_wb_i(we), .waddr_wb_i(wa), .wdata_wb_i(wd),
    .req_lsu_i(req), .waddr_lsu_i(la), .wdata_lsu_i(ld),
    .gnt_lsu_o(d1_gnt), .stall_wb_o(d1_stall),
    .rf_we_o(d1_we), .rf_waddr_o(d1_addr), .rf_wdata_o(d1_data), .err_o(d1_err));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model (32-register instance): scrub is a queue of addresses
  // still to be zeroed; RUN keeps the last visible write and a blocked count.
  int          m_q[$];
  int          m_blk = 0;
  bit          m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_err = 1'b0;
  bit          m_pstall = 1'b1;

  task automatic model_check();
    bit ini;
    if (!rst_n) begin
      chk("rst_done", 32'(d0_done), 32'd0);
      chk("rst_gnt", 32'(d0_gnt), 32'd0);
      chk("rst_stall", 32'(d0_stall), 32'd1);
      chk("rst_err", 32'(d0_err), 32'd0);
      chk("rst_rf_we", 32'(d0_we), 32'd0);
    end else begin
      ini = (m_q.size() != 0);
      chk("m_done", 32'(d0_done), 32'(!ini));
      chk("m_gnt", 32'(d0_gnt), 32'(!ini && req && !we));
      chk("m_stall", 32'(d0_stall), 32'(ini || (m_blk >= int'(MAXW))));
      chk("m_rf_we", 32'(d0_we), 32'(ini || m_we));
      chk("m_rf_addr", 32'(d0_addr), ini ? m_q[0] : 32'(m_addr));
      chk("m_rf_data", d0_data, ini ? 32'h0 : m_data);
      chk("m_err", 32'(d0_err), 32'(m_err));
    end
  endtask

  task automatic model_advance();
    bit g, st;
    logic [4:0]  a;
    if (!rst_n) begin
      m_q.delete();
      for (int i = 1; i < 32; i++) m_q.push_back(i);
      m_blk = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0; m_pstall = 1'b1;
    end else if (m_q.size() != 0) begin
      m_addr = 5'(m_q.pop_front());
      m_data = '0; m_we = 1'b0; m_err = we; m_blk = 0; m_pstall = 1'b1;
    end else begin
      g  = req && !we;
      st = (m_blk >= int'(MAXW));
      if (we || g) begin
        a = we ? wa : la;
        m_err = we && m_pstall;
        if (a != 0) begin
          m_we = 1'b1; m_addr = a; m_data = we ? wd : ld;
        end else begin
          m_we = 1'b0;
        end
      end else begin
        m_we = 1'b0; m_err = 1'b0;
        if (init_req) for (int i = 1; i < 32; i++) m_q.push_back(i);
      end
      m_blk = (req && !g) ? ((m_blk < 15) ? m_blk + 1 : 15) : 0;
      m_pstall = st;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic next();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic drive(input bit w, input logic [4:0] a, input logic [31:0] d,
                       input bit r, input logic [4:0] l, input logic [31:0] ldv, input bit ir);
    we = w; wa = a; wd = d; req = r; la = l; ld = ldv; init_req = ir;
  endtask

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic req; logic [4:0] la; logic [31:0] ld; logic ir;
    logic e_gnt; logic e_stall; logic e_done; logic e_we;
    logic [4:0] e_addr; logic [31:0] e_data; logic chk_ad;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit lsu_pend;
    bit granted;

    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd31, 32'h0, 1'b1};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
    tbl[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h11111111, 1'b1};
    tbl[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h11111111, 1'b1};
    tbl[4] = '{1'b1, 5'd0, 32'hAAAA5555, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h11111111, 1'b1};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
    tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
    tbl[7] = '{1'b1, 5'd7, 32'h0BADF00D, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
    tbl[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0BADF00D, 1'b1};
    tbl[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0BADF00D, 1'b1};

    // Reset, then the power-on scrub on both instances.
    rst_n = 1'b0;
    sample(); next();
    sample(); next();
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      sample();
      chk("init_we", 32'(d0_we), 32'd1);
      chk("init_addr", 32'(d0_addr), 32'(i));
      chk("init_data", d0_data, 32'h0);
      chk("init_done", 32'(d0_done), 32'd0);
      if (i <= 15) begin
        chk("e_init_we", 32'(d1_we), 32'd1);
        chk("e_init_addr", 32'(d1_addr), 32'(i));
      end else if (i == 16) begin
        chk("e_init_done", 32'(d1_done), 32'd1);
      end
      next();
    end
    sample();
    chk("run_done", 32'(d0_done), 32'd1);
    chk("run_we", 32'(d0_we), 32'd0);
    next();

    // Directed vectors: arbitration, staging latency, address-0 writes.
    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].req, tbl[i].la, tbl[i].ld, tbl[i].ir);
      sample();
      chk($sformatf("t%0d_gnt", i), 32'(d0_gnt), 32'(tbl[i].e_gnt));
      chk($sformatf("t%0d_stall", i), 32'(d0_stall), 32'(tbl[i].e_stall));
      chk($sformatf("t%0d_done", i), 32'(d0_done), 32'(tbl[i].e_done));
      chk($sformatf("t%0d_we", i), 32'(d0_we), 32'(tbl[i].e_we));
      if (tbl[i].chk_ad) begin
        chk($sformatf("t%0d_addr", i), 32'(d0_addr), 32'(tbl[i].e_addr));
        chk($sformatf("t%0d_data", i), d0_data, tbl[i].e_data);
      end
      next();
    end

    // 16-register instance: address 17 is out of range.
    drive(1'b1, 5'd17, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0, 1'b0);
    sample(); next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    sample();
    chk("e_bad_we", 32'(d1_we), 32'd0);
    chk("e_bad_err", 32'(d1_err), 32'd1);
    chk("bad_ok_addr", 32'(d0_addr), 32'd17);
    next();
    sample();
    chk("e_bad_err_end", 32'(d1_err), 32'd0);
    next();

    // LSU starved by back-to-back WB writes until the stall threshold.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 5'(k + 1), 32'(k), 1'b1, 5'd9, 32'h99, 1'b0);
      sample();
      if (k == 3) chk("stall_below", 32'(d0_stall), 32'd0);
      if (k == 4) chk("stall_at", 32'(d0_stall), 32'd1);
      next();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0);
    sample();
    chk("stall_viol_err", 32'(d0_err), 32'd1);
    chk("stall_gnt", 32'(d0_gnt), 32'd1);
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    sample();
    chk("stall_drop", 32'(d0_stall), 32'd0);
    chk("lsu_we", 32'(d0_we), 32'd1);
    chk("lsu_addr", 32'(d0_addr), 32'd9);
    next();

    // Scrub request, LSU pending throughout, WB write in INIT, reset at cnt=10.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    sample(); next();
    for (int s = 1; s <= 10; s++) begin
      drive(s == 3, 5'd4, 32'h44, 1'b1, 5'd12, 32'h1212, 1'b0);
      if (s == 10) rst_n = 1'b0;
      sample();
      if (s < 10) begin
        chk("scrub_addr", 32'(d0_addr), 32'(s));
        chk("scrub_gnt", 32'(d0_gnt), 32'd0);
      end
      if (s == 4) chk("init_we_err", 32'(d0_err), 32'd1);
      if (s == 10) begin
        chk("mid_rst_done", 32'(d0_done), 32'd0);
        chk("mid_rst_stall", 32'(d0_stall), 32'd1);
      end
      next();
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      sample();
      chk("rescrub_addr", 32'(d0_addr), 32'(i));
      chk("rescrub_we", 32'(d0_we), 32'd1);
      next();
    end
    sample();
    chk("pend_gnt", 32'(d0_gnt), 32'd1);
    next();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    sample();
    chk("pend_addr", 32'(d0_addr), 32'd12);
    chk("pend_data", d0_data, 32'h1212);
    next();

    // Randomized traffic against the model.
    lsu_pend = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (!lsu_pend && ($urandom % 10 < 5)) begin
        lsu_pend = 1'b1;
        la = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ld = $urandom;
      end
      req = lsu_pend;
      we = ($urandom % 10 < 4);
      wa = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wd = $urandom;
      init_req = ($urandom % 50 == 0);
      granted = rst_n && (m_q.size() == 0) && req && !we;
      sample();
      next();
      if (granted || !rst_n) lsu_pend = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_rf_wr_ctrl.md
IBEX_RF_WR_CTRL -- requirements
Module: ibex_rf_wr_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line.
  RV32E, 0, 16-register mode: NUM_WORDS=16, else 32.
  DataWidth, 32, register word width.
  WordZeroVal, '0, value written during init and scrub.
  MaxWait, 4, LSU wait cycles before a WB stall request; range 1..15.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
  clk_i  in  1  sole clock.
  rst_ni  in  1  reset; synchronous, active-low.
  init_req_i  in  1  scrub request pulse.
  init_done_o  out  1  high in RUN.
  we_wb_i  in  1  WB-stage write strobe; no backpressure.
  waddr_wb_i  in  5  WB write address.
  wdata_wb_i  in  DataWidth  WB write data.
  req_lsu_i  in  1  LSU write request; held until granted.
  waddr_lsu_i  in  5  LSU write address.
  wdata_lsu_i  in  DataWidth  LSU write data.
  gnt_lsu_o  out  1  LSU grant, same cycle as request.
  stall_wb_o  out  1  core must not assert we_wb_i next cycle.
  rf_we_o  out  1  register file write enable.
  rf_waddr_o  out  5  register file write address.
  rf_wdata_o  out  DataWidth  register file write data.
  err_o  out  1  one-cycle protocol-violation pulse.

Function
REQ-003 Block SHALL have two states: INIT and RUN.
REQ-004 INIT SHALL use a counter cnt from 1 up to NUM_WORDS-1.
REQ-005 In INIT, rf_we_o SHALL be 1, rf_waddr_o SHALL be cnt, and rf_wdata_o SHALL be WordZeroVal, all decoded from registers.
REQ-006 In INIT, cnt SHALL increment each cycle; at cnt=NUM_WORDS-1 the next state SHALL be RUN.
REQ-007 INIT SHALL therefore last exactly NUM_WORDS-1 cycles: 31, or 15 when RV32E=1.
REQ-008 init_done_o SHALL be 1 only in RUN and SHALL be driven from the state register.
REQ-009 In INIT, gnt_lsu_o SHALL be 0 and stall_wb_o SHALL be 1.
REQ-010 If we_wb_i=1 in INIT, the write SHALL be dropped and err_o SHALL pulse in the next cycle.
REQ-011 A WB write in RUN SHALL always be accepted.
REQ-012 gnt_lsu_o SHALL equal req_lsu_i & ~we_wb_i & RUN, combinationally.
REQ-013 An accepted write in cycle N SHALL appear on rf_* in cycle N+1, with rf_we_o high for exactly one cycle.
REQ-014 There SHALL be no combinational path from request inputs to rf_*.
REQ-015 With no accepted write in cycle N, rf_we_o SHALL be 0 in cycle N+1; rf_waddr_o and rf_wdata_o SHALL hold their previous values.
REQ-016 An accepted write to address 0 SHALL complete its handshake but produce rf_we_o=0.
REQ-017 With RV32E=1, an accepted write with address bit 4 set SHALL be dropped and SHALL pulse err_o in cycle N+1.
REQ-018 A wait counter SHALL increment, saturating at 15, each RUN cycle with req_lsu_i=1 and gnt_lsu_o=0; it SHALL clear on grant or when req_lsu_i=0.
REQ-019 stall_wb_o SHALL be 1 in RUN when the wait counter is at least MaxWait.
REQ-020 If we_wb_i=1 in a cycle following one with stall_wb_o=1, WB SHALL still win and err_o SHALL pulse the next cycle.
REQ-021 init_req_i=1 in RUN SHALL be accepted only if no write is accepted that cycle; otherwise it SHALL be ignored.
REQ-022 When init_req_i is accepted, INIT SHALL be entered next cycle with cnt=1; the first scrub write SHALL follow any in-flight rf_* write.
REQ-023 init_req_i in INIT SHALL be ignored.
REQ-024 Simultaneous init_req_i and we_wb_i in RUN SHALL perform the write and ignore init_req_i.
REQ-025 The wait counter SHALL be held at 0 in INIT.
REQ-026 An LSU request pending across a scrub SHALL remain ungranted until RUN.

Reset
REQ-027 When rst_ni=0 at a clk_i edge, the block SHALL load: state=INIT, cnt=1, wait counter=0, output stage rf_we_o=0, rf_waddr_o=0, rf_wdata_o=WordZeroVal, err_o=0.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL restart the full init sequence.
REQ-029 Reset SHALL drop any pending staged write.
REQ-030 While rst_ni=0, outputs SHALL be: init_done_o=0, gnt_lsu_o=0, stall_wb_o=1, err_o=0.

Verification
REQ-031 Reset release, RV32E=0 -> rf_we_o=1 for 31 cycles with rf_waddr_o=1..31, rf_wdata_o=0; init_done_o rises in the 32nd cycle.
REQ-032 RUN: we_wb_i with addr 5, data 0xDEADBEEF, plus req_lsu_i with addr 6 -> gnt_lsu_o=0 that cycle; next cycle rf_we_o=1, addr 5, data 0xDEADBEEF; the LSU write to addr 6 follows in the next free cycle, with rf_we_o one cycle after grant.
REQ-033 MaxWait=4, LSU blocked by back-to-back WB writes -> stall_wb_o=1 after 4 wait cycles; one further WB write -> err_o pulse; WB idle -> LSU granted, stall_wb_o drops.
REQ-034 WB write to addr 0 -> rf_we_o=0; LSU write to addr 0 -> gnt_lsu_o=1, rf_we_o=0.
REQ-035 init_req_i in RUN, then rst_ni=0 for 1 cycle mid-scrub at cnt=10 -> scrub restarts at addr 1 and completes 31 writes.
REQ-036 RV32E=1: WB write to addr 17 -> no rf_we_o, err_o=1 for one cycle; init lasts 15 cycles.
